// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use,
// branch, multi-cycle memory and halt events into register enables.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   load_use_hazard   ID depends on a load in EX
//   branch_taken      EX branch resolved taken
//   dmem_req          MEM stage holds a load or store
//   halt_req          WB retires ecall/ebreak
//   pc_write..mem_wb_write  per-stage register write enables
//   if_id_flush, id_ex_flush  insert NOP into IF/ID, ID/EX
//   halted            pipeline permanently stopped
//   stall_cycles      saturating count of cycles with pc_write=0
//   flush_count       saturating count of branch flushes
module pipeline_stall_ctrl #(
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int WCNT_W          = 4,
    parameter int PERF_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_use_hazard,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              halt_req,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              mem_wb_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        HALTED
    } state_e;

    localparam bit MEM_ON = (MEM_WAIT_CYCLES > 0);
    localparam logic [WCNT_W-1:0] WAIT_INIT =
        MEM_ON ? WCNT_W'(MEM_WAIT_CYCLES - 1) : '0;
    localparam logic [PERF_W-1:0] SAT = {PERF_W{1'b1}};

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              served_q, served_d;
    logic              halted_q, halted_d;
    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] flush_q, flush_d;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    logic [6:0] ctrl;
    logic       advance;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        served_d = 1'b0;
        halted_d = halted_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        ctrl     = '0;
        advance  = 1'b0;

        case (state_q)
            RUN: begin
                // served_q marks the release cycle of a one-cycle
                // access, where a held dmem_req must not re-trigger.
                if (MEM_ON && !served_q && dmem_req) begin
                    wcnt_d = WAIT_INIT;
                    if (MEM_WAIT_CYCLES == 1) begin
                        served_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    advance = 1'b1;
                    state_d = RUN;
                end
            end
            HALTED: begin
            end
            default: state_d = RUN;
        endcase

        if (advance) begin
            if (halt_req) begin
                state_d  = HALTED;
                halted_d = 1'b1;
            end else if (branch_taken) begin
                // Branch wins over load-use: the dependent
                // instruction is on the wrong path anyway.
                ctrl = 7'b1111111;
                if (flush_q != SAT) flush_d = flush_q + 1'b1;
            end else if (load_use_hazard) begin
                ctrl = 7'b0011101;
            end else begin
                ctrl = 7'b1111100;
            end
        end

        if (state_q != HALTED && !ctrl[6] && stall_q != SAT) begin
            stall_d = stall_q + 1'b1;
        end

        if (reset) ctrl = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            wcnt_q   <= '0;
            served_q <= 1'b0;
            halted_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            served_q <= served_d;
            halted_q <= halted_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign pc_write     = ctrl[6];
    assign if_id_write  = ctrl[5];
    assign id_ex_write  = ctrl[4];
    assign ex_mem_write = ctrl[3];
    assign mem_wb_write = ctrl[2];
    assign if_id_flush  = ctrl[1];
    assign id_ex_flush  = ctrl[0];
    assign halted       = halted_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: directed plan steps followed by
// random stimulus, all checked against a cycle-level reference model.
module tb_pipeline_stall_ctrl;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset, lu, br, dm, hr;
    logic        pc_write, if_id_write, id_ex_write;
    logic        ex_mem_write, mem_wb_write;
    logic        if_id_flush, id_ex_flush, halted;
    logic [31:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MEM_WAIT_CYCLES(N),
        .WCNT_W(4),
        .PERF_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_use_hazard(lu),
        .branch_taken(br),
        .dmem_req(dm),
        .halt_req(hr),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write),
        .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .halted(halted),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    // Reference model: frozen cycles still owed, forced-advance flag,
    // halt flag, and plain integer counters.
    bit          m_halt;
    int          m_left;
    bit          m_rel;
    longint      m_stall, m_flush;
    int          errors = 0;
    int          checks = 0;

    task automatic step(input bit r, input bit l, input bit b,
                        input bit d, input bit h);
        logic [6:0] exp_c, obs_c;
        bit         frz;
        @(negedge clk);
        reset = r; lu = l; br = b; dm = d; hr = h;
        #1;
        exp_c = 7'b0;
        frz   = 1'b1;
        if (!r && !m_halt) begin
            if (m_left > 0) begin
                frz = 1'b1;
            end else if (!m_rel && d && N > 0) begin
                frz = 1'b1;
            end else begin
                frz = 1'b0;
                if (h)      exp_c = 7'b0000000;
                else if (b) exp_c = 7'b1111111;
                else if (l) exp_c = 7'b0011101;
                else        exp_c = 7'b1111100;
            end
        end
        obs_c = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 mem_wb_write, if_id_flush, id_ex_flush};
        checks++;
        assert (obs_c === exp_c) else begin
            errors++;
            $error("FAIL ctrl obs=%b exp=%b", obs_c, exp_c);
        end
        checks++;
        assert (halted === m_halt) else begin
            errors++;
            $error("FAIL halted obs=%b exp=%b", halted, m_halt);
        end
        checks++;
        assert (stall_cycles === 32'(m_stall)) else begin
            errors++;
            $error("FAIL stall obs=%0d exp=%0d", stall_cycles, m_stall);
        end
        checks++;
        assert (flush_count === 32'(m_flush)) else begin
            errors++;
            $error("FAIL flush obs=%0d exp=%0d", flush_count, m_flush);
        end
        // Advance model to the state after the coming clock edge.
        if (r) begin
            m_halt = 0; m_left = 0; m_rel = 0;
            m_stall = 0; m_flush = 0;
        end else if (!m_halt) begin
            if (exp_c[6] == 1'b0 && m_stall < 64'hFFFF_FFFF)
                m_stall++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_rel = 1;
            end else if (frz) begin
                m_left = N - 1;
                if (m_left == 0) m_rel = 1;
            end else begin
                m_rel = 0;
                if (h) m_halt = 1;
                else if (b && m_flush < 64'hFFFF_FFFF) m_flush++;
            end
        end
    endtask

    initial begin
        reset = 1; lu = 0; br = 0; dm = 0; hr = 0;
        m_halt = 0; m_left = 0; m_rel = 0; m_stall = 0; m_flush = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0,
                 1'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 39) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
